// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types and constants for the RAM port arbiter
// Purpose: FSM state enum, requester count, default geometry and sizing helpers.
// Ports: none (package ram_arb_pkg).
package ram_arb_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

  localparam int NUM_REQ    = 2;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 32;
  localparam int BE_W       = RAM_DATA_W / 8;
  localparam int DEPTH      = 2 ** RAM_ADDR_W;

  // Sizing helpers for parameterised instances that differ from the defaults
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - client-side write/read request bus for the RAM port arbiter
// Purpose: bundles both requesters' write and read handshakes.
// Ports (modport slave = arbiter side):
//   wr_valid/wr_ready [NUM_REQ], wr_addr/wr_be/wr_data packed per requester,
//   rd_valid/rd_ready [NUM_REQ], rd_addr packed per requester,
//   rd_rvalid [NUM_REQ] one-hot response strobe, rd_rdata shared response data.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic [NUM_REQ-1:0]              wr_valid;
  logic [NUM_REQ-1:0]              wr_ready;
  logic [NUM_REQ*ADDR_W-1:0]       wr_addr;
  logic [NUM_REQ*(DATA_W/8)-1:0]   wr_be;
  logic [NUM_REQ*DATA_W-1:0]       wr_data;
  logic [NUM_REQ-1:0]              rd_valid;
  logic [NUM_REQ-1:0]              rd_ready;
  logic [NUM_REQ*ADDR_W-1:0]       rd_addr;
  logic [NUM_REQ-1:0]              rd_rvalid;
  logic [DATA_W-1:0]               rd_rdata;

  modport master (
    output wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_rvalid, rd_rdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_rvalid, rd_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - two-way round-robin arbiter
// Purpose: grants one of two requesters per cycle; on contention the requester
//          that was not granted last wins.
// Ports: clk, rst (async active-high), en (arbitration enabled),
//        valid[1:0] requests in, grant[1:0] one-hot or zero out.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // Index of the requester granted most recently
  logic last;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b0;
    end else if (grant != 2'b00) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - sequencer/arbiter sharing a dual-port byte-enable RAM
// Purpose: round-robin arbitration of two requesters on the RAM write port and
//          read port independently, plus a zero-fill sweep after reset or on
//          clr_start. Optional macro RD_WR_BYPASS_EN forwards same-cycle
//          same-address write bytes into the following read response.
// Ports: clk, rst (async active-high); clr_start in, clr_busy out;
//        bus (ram_port_arbiter_if.slave) client requests and read responses;
//        ram_wr_en/ram_byte_en/ram_wr_addr/ram_data_in, ram_rd_en/ram_rd_addr
//        to the RAM; ram_data_out from the RAM (1-cycle registered read).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W        = RAM_ADDR_W,
  parameter int DATA_W        = RAM_DATA_W,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_start,
  output logic                clr_busy,
  ram_port_arbiter_if.slave   bus,
  output logic                ram_wr_en,
  output logic [DATA_W/8-1:0] ram_byte_en,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic [DATA_W-1:0]   ram_data_in,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [DATA_W-1:0]   ram_data_out
);

  localparam int BYTES = be_w(DATA_W);

  arb_state_e        state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              arb_en;
  logic [1:0]        wr_grant;
  logic [1:0]        rd_grant;
  logic [1:0]        rd_rvalid_q;
  logic [DATA_W-1:0] rd_merged;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT_ON_RESET ? CLEAR : RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    arb_en      = 1'b0;
    clr_busy    = 1'b0;
    case (state)
      RUN: begin
        arb_en = 1'b1;
        if (clr_start) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_busy    = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        // Last word of the sweep: counter wraps to zero on its own
        if (&clr_cnt) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // ---------------- Arbiters ----------------
  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .valid (bus.wr_valid),
    .grant (wr_grant)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .valid (bus.rd_valid),
    .grant (rd_grant)
  );

  assign bus.wr_ready = wr_grant;
  assign bus.rd_ready = rd_grant;

  // ---------------- Write port ----------------
  always_comb begin
    ram_wr_en   = 1'b0;
    ram_byte_en = '0;
    ram_wr_addr = '0;
    ram_data_in = '0;
    if (state == CLEAR) begin
      ram_wr_en   = 1'b1;
      ram_byte_en = '1;
      ram_wr_addr = clr_cnt;
    end else if (wr_grant[0]) begin
      ram_wr_en   = 1'b1;
      ram_byte_en = bus.wr_be[0 +: BYTES];
      ram_wr_addr = bus.wr_addr[0 +: ADDR_W];
      ram_data_in = bus.wr_data[0 +: DATA_W];
    end else if (wr_grant[1]) begin
      ram_wr_en   = 1'b1;
      ram_byte_en = bus.wr_be[BYTES +: BYTES];
      ram_wr_addr = bus.wr_addr[ADDR_W +: ADDR_W];
      ram_data_in = bus.wr_data[DATA_W +: DATA_W];
    end
  end

  // ---------------- Read port ----------------
  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    if (rd_grant[0]) begin
      ram_rd_en   = 1'b1;
      ram_rd_addr = bus.rd_addr[0 +: ADDR_W];
    end else if (rd_grant[1]) begin
      ram_rd_en   = 1'b1;
      ram_rd_addr = bus.rd_addr[ADDR_W +: ADDR_W];
    end
  end

  // The RAM registers its read, so the strobe just follows the grant by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_rvalid_q <= 2'b00;
    end else begin
      rd_rvalid_q <= rd_grant;
    end
  end

`ifdef RD_WR_BYPASS_EN
  logic             byp_hit;
  logic [BYTES-1:0] byp_be_q;
  logic [DATA_W-1:0] byp_data_q;

  // Only arbitrated traffic can collide; the sweep never reads
  assign byp_hit = ram_wr_en && ram_rd_en && (ram_wr_addr == ram_rd_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else begin
      byp_be_q   <= byp_hit ? ram_byte_en : '0;
      byp_data_q <= ram_data_in;
    end
  end

  always_comb begin
    rd_merged = ram_data_out;
    for (int b = 0; b < BYTES; b++) begin
      if (byp_be_q[b]) begin
        rd_merged[b*8 +: 8] = byp_data_q[b*8 +: 8];
      end
    end
  end
`else
  assign rd_merged = ram_data_out;
`endif

  // Zero outside a response keeps the shared data bus deterministic
  assign bus.rd_rvalid = rd_rvalid_q;
  assign bus.rd_rdata  = (|rd_rvalid_q) ? rd_merged : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start;
  logic          clr_busy;
  logic          ram_wr_en;
  logic [BW-1:0] ram_byte_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_data_out;

  int errors = 0;
  int checks = 0;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_ON_RESET(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy),
    .bus          (bus),
    .ram_wr_en    (ram_wr_en),
    .ram_byte_en  (ram_byte_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM device: registered read, read-before-write on collision
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_rd_en) ram_data_out <= ram[ram_rd_addr];
    if (ram_wr_en)
      for (int b = 0; b < BW; b++)
        if (ram_byte_en[b]) ram[ram_wr_addr][b*8 +: 8] <= ram_data_in[b*8 +: 8];
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_clear;
  int            m_idx;
  bit            m_last_wr, m_last_rd;
  logic [1:0]    m_pend_rv;
  logic [DW-1:0] m_pend_data;

  logic [1:0]    e_wr_ready, e_rd_ready, e_rvalid;
  logic [DW-1:0] e_rdata, e_wdata;
  logic          e_busy, e_wr_en, e_rd_en;
  logic [BW-1:0] e_be;
  logic [AW-1:0] e_waddr, e_raddr;

  function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
    int w;
    if (v == 2'b00) return 2'b00;
    if (v == 2'b11) w = last ? 0 : 1;
    else w = v[1] ? 1 : 0;
    return 2'(1 << w);
  endfunction

  task automatic model_reset();
    m_clear = 1'b1; m_idx = 0; m_last_wr = 1'b0; m_last_rd = 1'b0;
    m_pend_rv = 2'b00; m_pend_data = '0;
  endtask

  // Expected outputs for the current cycle's inputs, then advance one clock
  task automatic model_cycle();
    int w, r;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] rdv;
    e_rvalid = m_pend_rv; e_rdata = m_pend_data; e_busy = m_clear;
    e_wr_ready = 2'b00; e_rd_ready = 2'b00; e_wr_en = 1'b0; e_be = '0;
    e_waddr = '0; e_wdata = '0; e_rd_en = 1'b0; e_raddr = '0;
    if (m_clear) begin
      e_wr_en = 1'b1; e_be = '1; e_waddr = AW'(m_idx);
      m_mem[m_idx] = '0; m_pend_rv = 2'b00;
      m_idx++;
      if (m_idx == DEPTH) begin m_clear = 1'b0; m_idx = 0; end
    end else begin
      e_wr_ready = pick(bus.wr_valid, m_last_wr);
      e_rd_ready = pick(bus.rd_valid, m_last_rd);
      rdv = '0; ra = '0;
      if (e_rd_ready != 2'b00) begin
        r = e_rd_ready[1] ? 1 : 0;
        ra = bus.rd_addr[r*AW +: AW];
        rdv = m_mem[ra];
        m_last_rd = e_rd_ready[1];
        e_rd_en = 1'b1; e_raddr = ra;
      end
      if (e_wr_ready != 2'b00) begin
        w = e_wr_ready[1] ? 1 : 0;
        wa = bus.wr_addr[w*AW +: AW];
        e_wr_en = 1'b1; e_be = bus.wr_be[w*BW +: BW]; e_waddr = wa;
        e_wdata = bus.wr_data[w*DW +: DW];
        for (int b = 0; b < BW; b++)
          if (e_be[b]) m_mem[wa][b*8 +: 8] = e_wdata[b*8 +: 8];
        m_last_wr = e_wr_ready[1];
`ifdef RD_WR_BYPASS_EN
        if (e_rd_en && wa == ra) rdv = m_mem[ra];
`endif
      end
      m_pend_rv = e_rd_ready; m_pend_data = rdv;
      if (clr_start) begin m_clear = 1'b1; m_idx = 0; end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.wr_valid = 2'b00; bus.wr_addr = '0; bus.wr_be = '0; bus.wr_data = '0;
    bus.rd_valid = 2'b00; bus.rd_addr = '0; clr_start = 1'b0;
  endtask

  task automatic advance();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", clr_busy); end
    checks++; if (bus.rd_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=00", bus.rd_rvalid); end
    checks++; if ({bus.wr_ready, bus.rd_ready} !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", {bus.wr_ready, bus.rd_ready}); end
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
  endtask

  task automatic test_init_sweep();
    for (int i = 0; i <= 256; i++) begin
      idle();
      if (i < 256) begin bus.wr_valid = 2'b11; bus.rd_valid = 2'b11; end
      @(negedge clk);
      model_cycle();
      if (i == 0 || i == 255) begin
        checks++; if (ram_wr_addr !== AW'(i)) begin errors++; $display("FAIL sweep_addr i=%0d got=%0d exp=%0d", i, ram_wr_addr, i); end
      end
      checks++; if (clr_busy !== e_busy) begin errors++; $display("FAIL sweep_busy i=%0d got=%b exp=%b", i, clr_busy, e_busy); end
      checks++; if ({bus.wr_ready, bus.rd_ready} !== {e_wr_ready, e_rd_ready}) begin errors++; $display("FAIL sweep_ready i=%0d got=%b exp=%b", i, {bus.wr_ready, bus.rd_ready}, {e_wr_ready, e_rd_ready}); end
      checks++; if ({ram_wr_en, ram_byte_en, ram_wr_addr, ram_data_in} !== {e_wr_en, e_be, e_waddr, e_wdata}) begin errors++; $display("FAIL sweep_wrport i=%0d got=%h exp=%h", i, {ram_wr_en, ram_byte_en, ram_wr_addr, ram_data_in}, {e_wr_en, e_be, e_waddr, e_wdata}); end
      checks++; if (ram_rd_en !== 1'b0) begin errors++; $display("FAIL sweep_rd_en i=%0d got=%b exp=0", i, ram_rd_en); end
      advance();
    end
  endtask

  task automatic test_rr_write();
    logic [1:0] exp;
    idle();
    bus.wr_valid = 2'b11; bus.wr_be = 8'hFF;
    bus.wr_addr = {8'h31, 8'h30}; bus.wr_data = {32'hCAFE0001, 32'hBEEF0000};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      model_cycle();
      exp = (k % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if (bus.wr_ready !== exp) begin errors++; $display("FAIL rr_wr_ready k=%0d got=%b exp=%b", k, bus.wr_ready, exp); end
      checks++; if (ram_wr_addr !== ((exp == 2'b10) ? 8'h31 : 8'h30)) begin errors++; $display("FAIL rr_wr_addr k=%0d got=%h", k, ram_wr_addr); end
      advance();
    end
  endtask

  task automatic test_be_write_read();
    idle();
    bus.wr_valid = 2'b10; bus.wr_addr[AW +: AW] = 8'h10;
    bus.wr_data[DW +: DW] = 32'hAABBCCDD; bus.wr_be[BW +: BW] = 4'b0101;
    @(negedge clk); model_cycle();
    checks++; if (bus.wr_ready !== 2'b10) begin errors++; $display("FAIL be_wr_ready got=%b exp=10", bus.wr_ready); end
    advance();
    idle();
    bus.rd_valid = 2'b01; bus.rd_addr[0 +: AW] = 8'h10;
    @(negedge clk); model_cycle();
    checks++; if ({bus.rd_ready, ram_rd_addr} !== {2'b01, 8'h10}) begin errors++; $display("FAIL be_rd_grant got=%b/%h exp=01/10", bus.rd_ready, ram_rd_addr); end
    advance();
    idle();
    @(negedge clk); model_cycle();
    checks++; if (bus.rd_rvalid !== 2'b01) begin errors++; $display("FAIL be_rvalid got=%b exp=01", bus.rd_rvalid); end
    checks++; if (bus.rd_rdata !== 32'h00BB00DD) begin errors++; $display("FAIL be_rdata got=%h exp=00bb00dd", bus.rd_rdata); end
    advance();
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] exp;
`ifdef RD_WR_BYPASS_EN
    exp = 32'h11223344;
`else
    exp = 32'h00000000;
`endif
    idle();
    bus.wr_valid = 2'b01; bus.wr_addr[0 +: AW] = 8'h20;
    bus.wr_data[0 +: DW] = 32'h11223344; bus.wr_be[0 +: BW] = 4'hF;
    bus.rd_valid = 2'b01; bus.rd_addr[0 +: AW] = 8'h20;
    @(negedge clk); model_cycle();
    checks++; if ({bus.wr_ready, bus.rd_ready} !== 4'b0101) begin errors++; $display("FAIL same_grants got=%b exp=0101", {bus.wr_ready, bus.rd_ready}); end
    advance();
    idle();
    @(negedge clk); model_cycle();
    checks++; if ({bus.rd_rvalid, bus.rd_rdata} !== {2'b01, exp}) begin errors++; $display("FAIL same_rdata got=%b/%h exp=01/%h", bus.rd_rvalid, bus.rd_rdata, exp); end
    advance();
  endtask

  task automatic test_clr_during_read();
    logic [AW-1:0] a;
    idle();
    bus.rd_valid = 2'b10; bus.rd_addr[AW +: AW] = 8'h10; clr_start = 1'b1;
    @(negedge clk); model_cycle();
    checks++; if ({clr_busy, bus.rd_ready} !== 3'b010) begin errors++; $display("FAIL clr_rd_grant got=%b exp=010", {clr_busy, bus.rd_ready}); end
    advance();
    idle();
    for (int i = 0; i <= 256; i++) begin
      bus.wr_valid = 2'b11; bus.wr_be = 8'hFF; bus.wr_data = {DW{2'b10}};
      if (i == 256) bus.wr_valid = 2'b00;
      @(negedge clk); model_cycle();
      if (i == 0) begin
        checks++; if ({bus.rd_rvalid, bus.rd_rdata} !== {2'b10, 32'h00BB00DD}) begin errors++; $display("FAIL clr_resp got=%b/%h exp=10/00bb00dd", bus.rd_rvalid, bus.rd_rdata); end
        checks++; if ({clr_busy, ram_wr_addr} !== {1'b1, 8'h00}) begin errors++; $display("FAIL clr_first got=%b/%h exp=1/00", clr_busy, ram_wr_addr); end
      end
      if (i < 256) begin
        checks++; if (bus.wr_ready !== 2'b00) begin errors++; $display("FAIL clr_wr_ready i=%0d got=%b exp=00", i, bus.wr_ready); end
      end else begin
        checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL clr_done got=%b exp=0", clr_busy); end
      end
      advance();
    end
    // pipelined reads of random addresses, each response must be zero
    for (int k = 0; k <= 8; k++) begin
      idle();
      if (k < 8) begin
        a = (k == 0) ? 8'h10 : (k == 1) ? 8'h20 : AW'($urandom_range(0, DEPTH - 1));
        bus.rd_valid = (k % 2 == 0) ? 2'b01 : 2'b10;
        bus.rd_addr = {a, a};
      end
      @(negedge clk); model_cycle();
      if (k > 0) begin
        checks++; if ({bus.rd_rvalid, bus.rd_rdata} !== {((k % 2 == 1) ? 2'b01 : 2'b10), 32'h0}) begin errors++; $display("FAIL clr_zero k=%0d got=%b/%h exp=0", k, bus.rd_rvalid, bus.rd_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 700; n++) begin
      bus.wr_valid = 2'($urandom_range(0, 3));
      bus.rd_valid = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        bus.wr_addr[r*AW +: AW] = AW'($urandom_range(0, 15));
        bus.rd_addr[r*AW +: AW] = AW'($urandom_range(0, 15));
        bus.wr_be[r*BW +: BW]   = BW'($urandom_range(0, 15));
        bus.wr_data[r*DW +: DW] = $urandom;
      end
      clr_start = ($urandom_range(0, 199) == 0);
      @(negedge clk); model_cycle();
      checks++; if (clr_busy !== e_busy) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, clr_busy, e_busy); end
      checks++; if ({bus.wr_ready, bus.rd_ready} !== {e_wr_ready, e_rd_ready}) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, {bus.wr_ready, bus.rd_ready}, {e_wr_ready, e_rd_ready}); end
      checks++; if ({ram_wr_en, ram_byte_en, ram_wr_addr, ram_data_in} !== {e_wr_en, e_be, e_waddr, e_wdata}) begin errors++; $display("FAIL rnd_wrport n=%0d got=%h exp=%h", n, {ram_wr_en, ram_byte_en, ram_wr_addr, ram_data_in}, {e_wr_en, e_be, e_waddr, e_wdata}); end
      checks++; if (ram_rd_en !== e_rd_en || (e_rd_en && ram_rd_addr !== e_raddr)) begin errors++; $display("FAIL rnd_rdport n=%0d got=%b/%h exp=%b/%h", n, ram_rd_en, ram_rd_addr, e_rd_en, e_raddr); end
      checks++; if (bus.rd_rvalid !== e_rvalid || (e_rvalid != 2'b00 && bus.rd_rdata !== e_rdata)) begin errors++; $display("FAIL rnd_resp n=%0d got=%b/%h exp=%b/%h", n, bus.rd_rvalid, bus.rd_rdata, e_rvalid, e_rdata); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int k = 0; k < 300 && m_clear; k++) begin
      @(negedge clk); model_cycle(); advance();
    end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL mid_settle got=%b exp=0", clr_busy); end
    bus.rd_valid = 2'b01; bus.rd_addr = {8'h05, 8'h05};
    @(negedge clk); model_cycle(); advance();
    idle();
    checks++; if (bus.rd_rvalid !== 2'b01) begin errors++; $display("FAIL mid_rvalid got=%b exp=01", bus.rd_rvalid); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({clr_busy, bus.rd_rvalid} !== 3'b100) begin errors++; $display("FAIL mid_rd_drop got=%b exp=100", {clr_busy, bus.rd_rvalid}); end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk); model_cycle();
      if (i == 0) begin
        checks++; if (ram_wr_addr !== 8'd0) begin errors++; $display("FAIL mid_start got=%0d exp=0", ram_wr_addr); end
      end
      if (i < 100) advance();
    end
    checks++; if ({clr_busy, ram_wr_addr} !== {1'b1, 8'd100}) begin errors++; $display("FAIL mid_at100 got=%b/%0d exp=1/100", clr_busy, ram_wr_addr); end
    rst = 1'b1;
    #1;
    checks++; if ({clr_busy, ram_wr_addr} !== {1'b1, 8'd0}) begin errors++; $display("FAIL mid_rst_cnt got=%b/%0d exp=1/0", clr_busy, ram_wr_addr); end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 0; j <= 256; j++) begin
      @(negedge clk); model_cycle();
      checks++; if ({clr_busy, ram_wr_en, ram_wr_addr} !== {e_busy, e_wr_en, e_waddr}) begin errors++; $display("FAIL mid_resweep j=%0d got=%b/%b/%0d exp=%b/%b/%0d", j, clr_busy, ram_wr_en, ram_wr_addr, e_busy, e_wr_en, e_waddr); end
      if (j == 0) begin
        checks++; if (ram_wr_addr !== 8'd0) begin errors++; $display("FAIL mid_restart got=%0d exp=0", ram_wr_addr); end
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = $urandom;
      m_mem[i] = 'x;
    end
    model_reset();
    test_reset();
    test_init_sweep();
    test_rr_write();
    test_be_write_read();
    test_same_addr();
    test_clr_during_read();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
